booth4: RTL and testbench
=========================

BOOTH4 -- requirements
Module: booth4

Interface
REQ-001 Parameter N, default 4, operand width in bits; SHALL be even and at least 4.
REQ-002 Port Clk, input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-003 Port Rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port A, input, N bits, multiplicand, signed two's complement.
REQ-005 Port B, input, N bits, multiplier, signed two's complement.
REQ-006 Port Z, output, 2N bits, registered product, signed two's complement.

Function
REQ-007 Z SHALL equal the exact signed product A*B; 2N bits always suffice, so there SHALL be no overflow or saturation (N=4 range: -56..+64).
REQ-008 The product SHALL use radix-4 Booth recoding of B into N/2 digits.
REQ-009 Digit i, for i = 0..N/2-1, SHALL be formed from B[2i+1], B[2i], B[2i-1], with B[-1] = 0.
- 000, 111 -> 0
- 001, 010 -> +1
- 011 -> +2
- 100 -> -2
- 101, 110 -> -1
REQ-010 Each partial product SHALL be the digit times A, sign-extended to 2N bits and shifted left by 2i.
- Negation by two's complement: invert plus one.
- +2/-2 formed by a left shift of one.
REQ-011 The sum of all partial products, taken modulo 2^2N, SHALL be the product.
REQ-012 Latency SHALL be one Clk cycle: Z after edge k reflects A and B sampled at edge k.
REQ-013 A new product SHALL be accepted every cycle; there is no handshake and no stall.
REQ-014 Operand value -2^(N-1) (e.g. -8 for N=4) SHALL be handled exactly, including -2 times it.

Reset
REQ-015 While Rst_n = 0, Z (and any internal pipeline register) SHALL be 0 immediately, independent of Clk.
REQ-016 Reset asserted mid-operation SHALL discard the in-flight product.
REQ-017 After deassertion, the first valid Z SHALL appear after the first rising Clk edge (the second edge when BOOTH4_INREG_EN is defined).

Configuration
REQ-018 Macro BOOTH4_INREG_EN:
- Defined: A and B are registered before Booth recoding; latency becomes 2 cycles; input registers reset to 0.
- Undefined: no input registers; latency is 1 cycle.
- The function is otherwise identical in both cases.

Structure
REQ-019 Package booth4_pkg SHALL hold the Booth digit enumeration (ZERO, POS1, POS2, NEG1, NEG2) and the default width constant.
REQ-020 Sub-module booth4_enc SHALL take one B bit-triplet and A, and return the signed, sign-extended 2N-bit partial product (before shifting).
- booth4 SHALL instantiate booth4_enc N/2 times and sum the shifted outputs.

Verification
REQ-021 Reset scenarios:
- Rst_n=0 asynchronously at any time -> Z=0x00 without a Clk edge.
- Rst_n=0 with A=3, B=5 pending -> Z stays 0x00 while reset is held.
REQ-022 Simple products (N=4):
- A=3, B=5 -> Z=0x0F one cycle later.
- A=0x5 (5), B=0xA (-6) -> Z=0xE2 (-30).
REQ-023 Extremes (N=4):
- A=0x8, B=0x8 (-8*-8) -> Z=0x40.
- A=0x8, B=0x7 -> Z=0xC8 (-56).
REQ-024 Sign handling (N=4):
- A=0xF, B=0x1 -> Z=0xFF.
- A=0x7, B=0x0 -> Z=0x00.
REQ-025 Back-to-back operands changing every cycle -> each Z matches its operands with exact 1-cycle latency (2 cycles with BOOTH4_INREG_EN).
REQ-026 Exhaustive check of all 256 (A,B) pairs for N=4 -> Z equals the signed product in every case.

Source files
------------

// File: rtl/booth4_pkg.sv
// Shared types for the radix-4 Booth multiplier: digit enumeration, default
// operand width and the bit-triplet to digit decoder.
package booth4_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_enc.sv
// One Booth digit slice: decodes a multiplier bit-triplet and returns the
// signed partial product digit*A, sign-extended to 2N bits and not yet shifted.
module booth4_enc
  import booth4_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [2:0]     trip,
  input  logic [N-1:0]   a,
  output logic [2*N-1:0] pp
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] a_ext;
  logic [2*N-1:0] a_dbl;
  booth_digit_t   digit;

  assign a_ext = {{N{a[N-1]}}, a};
  assign a_dbl = a_ext << 1;
  assign digit = booth_decode(trip);

  // 2N bits hold -2 * -2^(N-1) = 2^N without wrapping.
  always_comb begin
    pp = '0;
    case (digit)
      ZERO:    pp = '0;
      POS1:    pp = a_ext;
      POS2:    pp = a_dbl;
      NEG1:    pp = ~a_ext + ONE;
      NEG2:    pp = ~a_dbl + ONE;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth4.sv
// Registered signed N x N radix-4 Booth multiplier, one product per cycle.
// Define BOOTH4_INREG_EN to register A/B ahead of the recoding (2-cycle latency).
module booth4
  import booth4_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Z
);

  localparam int D = N / 2;

  logic [N-1:0]   a_op;
  logic [N-1:0]   b_op;
  logic [2*N-1:0] pp [D];
  logic [2*N-1:0] sum;

`ifdef BOOTH4_INREG_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_op <= '0;
      b_op <= '0;
    end else begin
      a_op <= A;
      b_op <= B;
    end
  end
`else
  assign a_op = A;
  assign b_op = B;
`endif

  for (genvar i = 0; i < D; i++) begin : g_dig
    logic [2:0] trip;
    // The lowest digit sees an implicit zero below bit 0.
    if (i == 0) begin : g_lsb
      assign trip = {b_op[1:0], 1'b0};
    end else begin : g_hi
      assign trip = b_op[2*i+1:2*i-1];
    end

    booth4_enc #(.N(N)) u_enc (
      .trip (trip),
      .a    (a_op),
      .pp   (pp[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < D; i++) begin
      sum = sum + (pp[i] << (2 * i));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Z <= '0;
    else        Z <= sum;
  end

endmodule

// File: tb/tb_booth4.sv
// Self-checking bench for booth4 (N=4): reset behaviour, directed products,
// random back-to-back streams and an exhaustive sweep against integer arithmetic.
module tb_booth4;

  localparam int N = 4;
`ifdef BOOTH4_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           Clk   = 1'b0;
  logic           Rst_n = 1'b1;
  logic [N-1:0]   A     = '0;
  logic [N-1:0]   B     = '0;
  logic [2*N-1:0] Z;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];

  booth4 #(.N(N)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .A     (A),
    .B     (B),
    .Z     (Z)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa;
    int sb;
    int p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = sa * sb;
    return p[2*N-1:0];
  endfunction

  task automatic check(input string tag, input logic [2*N-1:0] expv);
    checks++;
    assert (Z === expv)
    else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, Z, expv);
    end
  endtask

  // Hold operands for the full latency, then compare against a fixed value.
  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] expv);
    @(negedge Clk);
    A = a;
    B = b;
    repeat (LAT) @(posedge Clk);
    #1;
    check(tag, expv);
  endtask

  // New operands every cycle; the model queue lines results up with their operands.
  task automatic stream(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge Clk);
    A = a;
    B = b;
    exp_q.push_back(ref_prod(a, b));
    @(posedge Clk);
    #1;
    if (exp_q.size() == LAT) check(tag, exp_q.pop_front());
  endtask

  initial begin
    // Asynchronous assertion before any clock edge.
    #2 Rst_n = 1'b0;
    #1 check("reset_async", 8'h00);

    A = 4'd3;
    B = 4'd5;
    repeat (3) begin
      @(posedge Clk);
      #1 check("reset_hold", 8'h00);
    end

    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1 check("first_edge", (LAT == 1) ? 8'h0F : 8'h00);
    @(posedge Clk);
    #1 check("second_edge", 8'h0F);

    directed("p3x5",      4'h3, 4'h5, 8'h0F);
    directed("p5xm6",     4'h5, 4'hA, 8'hE2);
    directed("m8xm8",     4'h8, 4'h8, 8'h40);
    directed("m8x7",      4'h8, 4'h7, 8'hC8);
    directed("m1x1",      4'hF, 4'h1, 8'hFF);
    directed("p7x0",      4'h7, 4'h0, 8'h00);
    directed("p7x7",      4'h7, 4'h7, 8'h31);
    directed("m8xp2",     4'h8, 4'h2, 8'hF0);

    // Reset in the middle of a stream discards in-flight products.
    for (int i = 0; i < 4; i++) stream("pre_reset", 4'($urandom), 4'($urandom));
    #2 Rst_n = 1'b0;
    #1 check("reset_mid", 8'h00);
    exp_q.delete();
    @(posedge Clk);
    #1 check("reset_mid_hold", 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 60; i++) stream("random", 4'($urandom), 4'($urandom));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        stream("exhaustive", 4'(a), 4'(b));
    stream("drain", 4'h0, 4'h0);
    stream("drain", 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
